cache_miss_ctrl: RTL and testbench

//  Sequencing controller between the pipeline MEM stage, the 256-entry direct-mapped data cache and

---
 rtl/cache_miss_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: sequences MEM-stage accesses through a direct-mapped cache,
// refills read misses from main memory and writes every store through to memory.
// Optional feature: define CACHE_PERF_CNT_EN to add saturating hit/miss counters.
module cache_miss_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CACHE_PERF_CNT_EN
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              stall,
    output logic              cache_cs,
    output logic              cache_we,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic              cache_miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_EVAL   = 3'd2,
        S_FETCH  = 3'd3,
        S_REFILL = 3'd4,
        S_WTHRU  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // State and latched transaction registers; reset abandons any memory handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and output decode; buses are zero in states that do not drive them.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cpu_ready   = 1'b0;
        stall       = 1'b0;
        cache_cs    = 1'b0;
        cache_we    = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
                stall = cpu_req;
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall       = 1'b1;
                cache_cs    = 1'b1;
                cache_we    = we_q;
                cache_addr  = addr_q;
                cache_wdata = we_q ? wdata_q : '0;
                state_d     = S_EVAL;
            end
            S_EVAL: begin
                stall = 1'b1;
                if (we_q) begin
                    // Stores always go to memory; the cache's miss flag is irrelevant.
                    state_d = S_WTHRU;
                end else if (cache_miss) begin
                    state_d = S_FETCH;
                end else begin
                    rdata_d = cache_rdata;
                    state_d = S_DONE;
                end
            end
            S_FETCH: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                stall       = 1'b1;
                cache_cs    = 1'b1;
                cache_we    = 1'b1;
                cache_addr  = addr_q;
                cache_wdata = rdata_q;
                state_d     = S_DONE;
            end
            S_WTHRU: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load data holds the last hit or fetched word.
    assign cpu_rdata = rdata_q;

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating load hit/miss counters, evaluated when the cache answer is seen.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_EVAL && !we_q) begin
            if (cache_miss) begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end else begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Testbench for cache_miss_ctrl: behavioural cache and memory around the DUT,
// expected responses queued at issue time and checked by an independent monitor.
module tb_cache_miss_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready, stall;
    logic          cache_cs, cache_we;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata, cache_rdata;
    logic          cache_miss;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ack;

    cache_miss_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .stall(stall),
        .cache_cs(cache_cs), .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_miss(cache_miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        bit            hit;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] rdata;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ready_cnt = 0;
    int            mem_delay = 0;
    bit            resp_en = 1'b1;

    // Reference model: architectural memory contents and which lines the cache holds.
    logic [DW-1:0] ref_mem [256];
    bit            ref_val [256];
    // Environment: backing memory and cache array written only by the DUT.
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] c_arr   [256];
    bit            c_val   [256];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural cache: answer a read in the following cycle, scramble otherwise.
    initial begin
        int hold;
        hold = 0;
        cache_rdata = '0;
        cache_miss  = 1'b0;
        forever begin
            @(negedge clk);
            if (cache_cs) begin
                if (cache_we) begin
                    c_arr[cache_addr] = cache_wdata;
                    c_val[cache_addr] = 1'b1;
                    cache_rdata = $urandom;
                    cache_miss  = 1'($urandom);
                    hold = 0;
                end else begin
                    cache_rdata = c_arr[cache_addr];
                    cache_miss  = !c_val[cache_addr];
                    hold = 1;
                end
            end else if (hold > 0) begin
                hold--;
            end else begin
                cache_rdata = $urandom;
                cache_miss  = 1'($urandom);
            end
        end
    end

    // Behavioural memory: ack mem_delay cycles after mem_req first appears.
    initial begin
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !resp_en) begin
                busy = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                busy = 1'b0;
                mem_rdata = $urandom;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = mem_delay;
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_arr[mem_addr];
                    end
                end else begin
                    cnt--;
                end
            end else begin
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks bus activity and completions against the queue head.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (q.size() == 0) begin
                check("idle_ready", 32'(cpu_ready), 32'd0);
                check("idle_mem_req", 32'(mem_req), 32'd0);
                check("idle_cache_cs", 32'(cache_cs), 32'd0);
                check("idle_stall", 32'(stall), 32'(cpu_req));
            end else begin
                exp_t h;
                h = q[0];
                if (cache_cs) begin
                    check("cache_addr", 32'(cache_addr), 32'(h.addr));
                    if (h.we) check("cache_we_store", 32'(cache_we), 32'd1);
                    if (cache_we) check("cache_wdata", cache_wdata, h.we ? h.data : h.rdata);
                end
                if (!h.we && h.hit) check("hit_mem_req", 32'(mem_req), 32'd0);
                if (mem_req) begin
                    check("mem_addr", 32'(mem_addr), 32'(h.addr));
                    check("mem_we", 32'(mem_we), 32'(h.we));
                    if (h.we) check("mem_wdata", mem_wdata, h.data);
                end
                if (cpu_ready) begin
                    check("latency", 32'(cyc - h.acc + 1), 32'(h.lat));
                    if (!h.we) check("cpu_rdata", cpu_rdata, h.rdata);
                    check("ready_stall", 32'(stall), 32'd0);
                    ready_cnt++;
                    void'(q.pop_front());
                end else begin
                    check("busy_stall", 32'(stall), 32'd1);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        check({tag, "_cache_cs"}, 32'(cache_cs), 32'd0);
        check({tag, "_cache_we"}, 32'(cache_we), 32'd0);
        check({tag, "_cache_addr"}, 32'(cache_addr), 32'd0);
        check({tag, "_cache_wdata"}, cache_wdata, 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cpu_req = 1'b0;
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
    endtask

    // Drive a request and queue its expected outcome from the reference model.
    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int dly, input bit commit);
        exp_t e;
        e.we    = we;
        e.addr  = a;
        e.data  = d;
        e.hit   = ref_val[a];
        e.rdata = ref_mem[a];
        e.acc   = cpu_ready ? cyc + 2 : cyc + 1;
        e.lat   = we ? 4 + dly : (ref_val[a] ? 3 : 5 + dly);
        if (commit) begin
            if (we) ref_mem[a] = d;
            ref_val[a] = 1'b1;
        end
        mem_delay = dly;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        q.push_back(e);
    endtask

    // Step past the acceptance edge, then scramble request fields.
    task automatic wait_accept(input bit keep);
        if (cpu_ready) tick();
        tick();
        cpu_req   = keep;
        cpu_we    = 1'($urandom);
        cpu_addr  = AW'($urandom);
        cpu_wdata = $urandom;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cpu_ready && n < 80) begin
            tick();
            n++;
        end
        if (!cpu_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no cpu_ready expected one within 80 cycles");
            do_reset();
        end
    endtask

    task automatic run_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int dly, input bit keep);
        issue(we, a, d, dly, 1'b1);
        wait_accept(keep);
        wait_ready();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        bit nb;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
            ref_val[i] = 1'b0;
            c_val[i]   = 1'b0;
            c_arr[i]   = $urandom;
        end
        mem_arr[34] = 32'd77;
        ref_mem[34] = 32'd77;

        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick();

        // Store write-through with a two-cycle memory wait, then hit and miss loads.
        run_txn(1'b1, 8'd1, 32'd15, 2, 1'b0);
        tick();
        run_txn(1'b0, 8'd1, 32'd0, 0, 1'b0);
        tick();
        run_txn(1'b0, 8'd34, 32'd0, 3, 1'b0);
        tick();
        run_txn(1'b0, 8'd34, 32'd0, 0, 1'b0);
        tick();

        // Reset asserted mid-cycle during ACCESS clears every output at once.
        issue(1'b0, 8'd5, 32'd0, 0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cpu_req = 1'b0;
        q.delete();
        #1;
        check_all_zero("rst_mid");
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Reset during FETCH: no refill, late ack ignored, next load still misses.
        issue(1'b0, 8'd2, 32'd0, 10, 1'b0);
        wait_accept(1'b0);
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        check("fetch_reached", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b1;
        resp_en = 1'b0;
        q.delete();
        #1;
        check("rst_fetch_mem_req", 32'(mem_req), 32'd0);
        check("rst_fetch_cache_cs", 32'(cache_cs), 32'd0);
        check("rst_fetch_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        repeat (4) tick();
        resp_en = 1'b1;
        run_txn(1'b0, 8'd2, 32'd0, 1, 1'b0);
        tick();

        // Three loads with cpu_req held high across them.
        base = ready_cnt;
        run_txn(1'b0, 8'd1, 32'd0, 0, 1'b1);
        run_txn(1'b0, 8'd34, 32'd0, 0, 1'b1);
        run_txn(1'b0, 8'd2, 32'd0, 0, 1'b0);
        tick();
        check("b2b_ready_pulses", 32'(ready_cnt - base), 32'd3);

        // Randomized traffic concentrated on a few lines so hits and misses both occur.
        for (int i = 0; i < 300; i++) begin
            bit            we;
            logic [AW-1:0] a;
            we = ($urandom_range(0, 9) < 4);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            nb = ($urandom_range(0, 2) == 0) && (i != 299);
            run_txn(we, a, $urandom, int'($urandom_range(0, 4)), nb);
            if (!nb) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        repeat (3) tick();

        for (int i = 0; i < 256; i++) begin
            check("final_mem", mem_arr[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
